// File: rtl/seg7_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg7_scan_ctrl -- time-multiplexed driver for an 8-digit common-anode
// seven-segment display.
//
// Each digit is driven for DRIVE_CYC cycles. Between digits there is a blank
// gap of GAP_CYC cycles with all anodes off, which stops ghosting. Digit
// values are held in an 8 x 5-bit register file: [3:0] is the hex nibble and
// [4] enables the decimal point. The file is written through wr_en/wr_addr/
// wr_data. All display outputs are active-low and registered.
//
// Ports
//   mclk        system clock, rising edge
//   clr         asynchronous active-low reset
//   pause       1 = freeze scan position and counters; outputs hold
//   wr_en       write strobe for the digit register file
//   wr_addr     digit index, 0 = rightmost
//   wr_data     {dp_enable, hex_nibble}
//   digit_en    per-digit enable mask (0 = always blank)
//   lz_en       1 = suppress leading zeros (digit 0 is never suppressed)
//   a_to_g      segments a..g on [6]..[0], active-low
//   AN          anodes, active-low, at most one low
//   dp          decimal point, active-low
//   frame_done  one-cycle pulse after the last digit of a scan completes
// ---------------------------------------------------------------------------
module seg7_scan_ctrl #(
  parameter int DRIVE_CYC = 100000,
  parameter int GAP_CYC   = 1000
) (
  input  logic       mclk,
  input  logic       clr,
  input  logic       pause,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [4:0] wr_data,
  input  logic [7:0] digit_en,
  input  logic       lz_en,
  output logic [6:0] a_to_g,
  output logic [7:0] AN,
  output logic       dp,
  output logic       frame_done
);

  localparam int MAX_CYC = (DRIVE_CYC > GAP_CYC) ? DRIVE_CYC : GAP_CYC;
  // The counter only has to reach MAX_CYC-1.
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DRIVE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC - 1);

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  typedef enum logic {
    ST_GAP,
    ST_DRIVE
  } state_t;

  // Active-low abcdefg pattern for one hex nibble.
  function automatic logic [6:0] hex_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       dig_q, dig_d;
  logic [4:0]       digit_q [8];
  logic [4:0]       digit_d [8];
  logic [6:0]       seg_q, seg_d;
  logic [7:0]       an_q, an_d;
  logic             dp_q, dp_d;
  logic             frame_q, frame_d;
  logic             lz_hit;

  // Digit register file: writes are taken every cycle, paused or not.
  always_comb begin
    digit_d = digit_q;
    if (wr_en) digit_d[wr_addr] = wr_data;
  end

  // Scan sequencing. The terminal-count transition is only taken when
  // pause is low, so a pause on the terminal cycle simply defers it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dig_d   = dig_q;
    frame_d = 1'b0;
    if (!pause) begin
      case (state_q)
        ST_GAP: begin
          if (cnt_q == GAP_LAST) begin
            state_d = ST_DRIVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          if (cnt_q == DRIVE_LAST) begin
            state_d = ST_GAP;
            cnt_d   = '0;
            dig_d   = dig_q + 3'd1;
            frame_d = (dig_q == 3'd7);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  // Leading-zero detect: the current digit and everything to its left
  // must have zero nibbles.
  always_comb begin
    lz_hit = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if ((3'(i) >= dig_q) && (digit_q[i][3:0] != 4'h0)) lz_hit = 1'b0;
    end
  end

  // Output decode. It uses the current state and register contents, so
  // the registered outputs trail them by one cycle. While paused the
  // output flops keep their values.
  always_comb begin
    seg_d = seg_q;
    an_d  = an_q;
    dp_d  = dp_q;
    if (!pause) begin
      seg_d = SEG_BLANK;
      an_d  = AN_OFF;
      dp_d  = 1'b1;
      if ((state_q == ST_DRIVE) && digit_en[dig_q]) begin
        an_d = ~(8'b1 << dig_q);
        dp_d = ~digit_q[dig_q][4];
        if (lz_en && (dig_q != 3'd0) && lz_hit) seg_d = SEG_BLANK;
        else                                    seg_d = hex_decode(digit_q[dig_q][3:0]);
      end
    end
  end

  // NOTE: the digit register file is reset along with the control state.
  // The display must read zero straight after reset, so it is built from
  // flops rather than from a RAM macro.
  always_ff @(posedge mclk or negedge clr) begin
    if (!clr) begin
      state_q <= ST_GAP;
      cnt_q   <= '0;
      dig_q   <= '0;
      seg_q   <= SEG_BLANK;
      an_q    <= AN_OFF;
      dp_q    <= 1'b1;
      frame_q <= 1'b0;
      for (int i = 0; i < 8; i++) digit_q[i] <= 5'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      dp_q    <= dp_d;
      frame_q <= frame_d;
      for (int i = 0; i < 8; i++) digit_q[i] <= digit_d[i];
    end
  end

  assign a_to_g     = seg_q;
  assign AN         = an_q;
  assign dp         = dp_q;
  assign frame_done = frame_q;

endmodule
